// File: rtl/hash_match_engine.sv
// rtl/hash_match_engine.sv - target-hash store and one-stage matcher with match FIFO
// Optional HME_STATS_EN adds saturating hash_count / dup_count outputs.
module hash_match_engine #(
    parameter int HASH_W     = 128,
    parameter int GUESS_W    = 128,
    parameter int NUM_HASH   = 64,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [7:0]         load_byte,
    input  logic               search_start,
    input  logic               hash_valid,
    output logic               hash_ready,
    input  logic [HASH_W-1:0]  hash_in,
    input  logic [GUESS_W-1:0] guess_in,
    output logic               match_valid,
    input  logic               match_ready,
    output logic [IDX_W-1:0]   match_idx,
    output logic [GUESS_W-1:0] match_guess,
    output logic [IDX_W:0]     slots_loaded,
    output logic               all_found,
`ifdef HME_STATS_EN
    output logic [31:0]        hash_count,
    output logic [15:0]        dup_count,
`endif
    output logic               load_ovf
);

    localparam int BYTES = HASH_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DONE} state_t;

    state_t               r_state;
    logic [HASH_W-1:0]    r_slot [NUM_HASH];
    logic [NUM_HASH-1:0]  r_valid;
    logic [NUM_HASH-1:0]  r_found;
    logic [HASH_W-1:0]    r_shift;
    logic [BC_W-1:0]      r_byte_cnt;
    logic [CNT_W-1:0]     r_slots_loaded;
    logic                 r_load_ovf;
    logic                 r_all_found;

    logic                 r_stage_valid;
    logic [HASH_W-1:0]    r_stage_hash;
    logic [GUESS_W-1:0]   r_stage_guess;

    logic [IDX_W-1:0]     r_fifo_idx   [FIFO_DEPTH];
    logic [GUESS_W-1:0]   r_fifo_guess [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;

`ifdef HME_STATS_EN
    logic [31:0]          r_hash_count;
    logic [15:0]          r_dup_count;
`endif

    logic                 w_store_full;
    logic                 w_byte_take;
    logic                 w_slot_done;
    logic [HASH_W-1:0]    w_shift_next;
    logic [CNT_W-1:0]     w_slots_next;
    logic [IDX_W-1:0]     w_wr_idx;
    logic                 w_accept;
    logic [NUM_HASH-1:0]  w_eq;
    logic [NUM_HASH-1:0]  w_found_next;
    logic                 w_hit;
    logic                 w_multi;
    logic [IDX_W-1:0]     w_hit_idx;
    logic                 w_pop;
    logic [PTR_W+1:0]     w_outstanding;

    assign w_store_full = (r_slots_loaded == CNT_W'(NUM_HASH));
    assign w_byte_take  = (r_state == S_LOAD) && load_valid && !w_store_full;
    assign w_slot_done  = w_byte_take && (r_byte_cnt == BC_W'(BYTES - 1));
    assign w_shift_next = (r_shift << 8) | HASH_W'(load_byte);
    assign w_slots_next = r_slots_loaded + CNT_W'(w_slot_done);
    assign w_wr_idx     = r_slots_loaded[IDX_W-1:0];

    // Stage entries count as outstanding so a hit can never find the FIFO full.
    assign w_outstanding = {1'b0, r_count} + (PTR_W+2)'(r_stage_valid);
    assign hash_ready    = (r_state == S_SEARCH) && (w_outstanding < (PTR_W+2)'(FIFO_DEPTH));
    assign w_accept      = hash_valid && hash_ready;

    always_comb begin
        w_eq = '0;
        for (int i = 0; i < NUM_HASH; i++) begin
            w_eq[i] = r_stage_valid && r_valid[i] && !r_found[i] && (r_slot[i] == r_stage_hash);
        end
    end

    always_comb begin
        w_hit_idx = '0;
        for (int i = NUM_HASH - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_hit        = |w_eq;
    assign w_multi      = |(w_eq & (w_eq - NUM_HASH'(1)));
    assign w_found_next = r_found | w_eq;
    assign w_pop        = (r_count != '0) && match_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= S_IDLE;
            r_valid        <= '0;
            r_found        <= '0;
            r_shift        <= '0;
            r_byte_cnt     <= '0;
            r_slots_loaded <= '0;
            r_load_ovf     <= 1'b0;
            r_all_found    <= 1'b0;
            r_stage_valid  <= 1'b0;
            r_stage_hash   <= '0;
            r_stage_guess  <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
`ifdef HME_STATS_EN
            r_hash_count   <= '0;
            r_dup_count    <= '0;
`endif
        end else if (load_start) begin
            r_state        <= S_LOAD;
            r_valid        <= '0;
            r_found        <= '0;
            r_shift        <= '0;
            r_byte_cnt     <= '0;
            r_slots_loaded <= '0;
            r_load_ovf     <= 1'b0;
            r_all_found    <= 1'b0;
            r_stage_valid  <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
`ifdef HME_STATS_EN
            r_hash_count   <= '0;
            r_dup_count    <= '0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load_valid && w_store_full) begin
                        r_load_ovf <= 1'b1;
                    end
                    if (w_byte_take) begin
                        r_shift <= w_shift_next;
                        if (w_slot_done) begin
                            r_byte_cnt        <= '0;
                            r_valid[w_wr_idx] <= 1'b1;
                            r_slots_loaded    <= w_slots_next;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        end
                    end
                    // A byte arriving with search_start is taken first; a leftover partial slot is dropped.
                    if (search_start) begin
                        r_byte_cnt <= '0;
                        if (w_slots_next != '0) begin
                            r_state <= S_SEARCH;
                        end else begin
                            r_state     <= S_DONE;
                            r_all_found <= 1'b1;
                        end
                    end
                end
                S_SEARCH: begin
                    if (w_hit && (w_found_next == r_valid)) begin
                        r_state     <= S_DONE;
                        r_all_found <= 1'b1;
                    end
                end
                default: ;
            endcase

            r_stage_valid <= w_accept;
            if (w_accept) begin
                r_stage_hash  <= hash_in;
                r_stage_guess <= guess_in;
            end
            if (w_hit) begin
                r_found  <= w_found_next;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_hit, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: ;
            endcase
`ifdef HME_STATS_EN
            if (w_accept && (r_hash_count != 32'hFFFF_FFFF)) begin
                r_hash_count <= r_hash_count + 32'd1;
            end
            if (w_multi && (r_dup_count != 16'hFFFF)) begin
                r_dup_count <= r_dup_count + 16'd1;
            end
`endif
        end
    end

    // Payload storage needs no reset: the valid mask and FIFO count qualify every read.
    always_ff @(posedge clk) begin
        if (w_slot_done && !load_start) begin
            r_slot[w_wr_idx] <= w_shift_next;
        end
        if (w_hit && !load_start) begin
            r_fifo_idx[r_wr_ptr]   <= w_hit_idx;
            r_fifo_guess[r_wr_ptr] <= r_stage_guess;
        end
    end

    assign match_valid  = (r_count != '0);
    assign match_idx    = match_valid ? r_fifo_idx[r_rd_ptr]   : '0;
    assign match_guess  = match_valid ? r_fifo_guess[r_rd_ptr] : '0;
    assign slots_loaded = r_slots_loaded;
    assign all_found    = r_all_found;
    assign load_ovf     = r_load_ovf;
`ifdef HME_STATS_EN
    assign hash_count   = r_hash_count;
    assign dup_count    = r_dup_count;
`endif

endmodule
